// File: rtl/bc_row_driver.sv
// Row driver feeding a PE chain from a command plus word stream.
// Optional BC_DRV_PERF_CNT_EN adds a saturating stream bubble counter.
module bc_row_driver #(
  parameter int GF_BIT      = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int N_PE        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_CODE_LEN-1:0] cmd_op,
  input  logic [1:0]             cmd_gauss,
  input  logic [7:0]             cmd_len,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [GF_BIT-1:0]      s_data,
  input  logic [GF_BIT-1:0]      s_dataA,
  input  logic [GF_BIT-1:0]      s_dataB,
  output logic                   start_out,
  output logic [OP_CODE_LEN-1:0] op_out,
  output logic [1:0]             gauss_op_out,
  output logic [GF_BIT-1:0]      data_out,
  output logic [GF_BIT-1:0]      dataA_out,
  output logic [GF_BIT-1:0]      dataB_out,
  input  logic [GF_BIT-1:0]      res_in,
  output logic                   m_valid,
  output logic [GF_BIT-1:0]      m_data,
`ifdef BC_DRV_PERF_CNT_EN
  output logic [15:0]            stall_cnt,
`endif
  output logic                   done
);

  localparam int DW = (N_PE > 1) ? $clog2(N_PE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t                 state;
  logic [7:0]             cnt;
  logic [7:0]             len_q;
  logic [OP_CODE_LEN-1:0] op_q;
  logic [1:0]             gauss_q;
  logic [DW-1:0]          dcnt;
  logic [N_PE-1:0]        tags;
  logic                   done_q;

  logic issue;
  logic last_word;
  logic drain_end;

  assign issue     = (state == STREAM) && s_valid;
  assign last_word = issue && (cnt == len_q - 8'd1);
  assign drain_end = (state == DRAIN) && (dcnt == DW'(N_PE - 1));

  assign cmd_ready    = (state == IDLE);
  assign s_ready      = (state == STREAM);
  assign start_out    = issue && (cnt == 8'd0);
  assign op_out       = issue ? op_q    : '0;
  assign gauss_op_out = issue ? gauss_q : 2'b00;
  assign data_out     = issue ? s_data  : '0;
  assign dataA_out    = issue ? s_dataA : '0;
  assign dataB_out    = issue ? s_dataB : '0;

  assign m_valid = tags[N_PE-1];
  assign m_data  = res_in;
  assign done    = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      len_q   <= 8'd0;
      op_q    <= '0;
      gauss_q <= 2'b00;
      dcnt    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            gauss_q <= cmd_gauss;
            len_q   <= cmd_len;
            cnt     <= 8'd0;
            if (cmd_len == 8'd0) done_q <= 1'b1;
            else                 state  <= STREAM;
          end
        end
        STREAM: begin
          if (s_valid) begin
            cnt <= cnt + 8'd1;
            if (last_word) begin
              state <= DRAIN;
              dcnt  <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_end) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // tag i marks a real word sitting at chain position i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags <= '0;
    end else begin
      tags[0] <= issue;
      for (int i = 1; i < N_PE; i++) tags[i] <= tags[i-1];
    end
  end

`ifdef BC_DRV_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (cmd_valid && state == IDLE) begin
      stall_cnt <= 16'd0;
    end else if (state == STREAM && !s_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bc_row_driver.sv
// Randomized bench for bc_row_driver against a cycle-schedule model.
// Build with or without BC_DRV_PERF_CNT_EN.
module tb_bc_row_driver;

  localparam int NPE  = 4;
  localparam int MAXC = 20000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_gauss;
  logic [7:0] cmd_len;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_data, s_dataA, s_dataB;
  logic       start_out;
  logic [3:0] op_out;
  logic [1:0] gauss_op_out;
  logic [3:0] data_out, dataA_out, dataB_out;
  logic [3:0] res_in;
  logic       m_valid;
  logic [3:0] m_data;
  logic       done;
`ifdef BC_DRV_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  bc_row_driver #(
    .GF_BIT(4), .OP_CODE_LEN(4), .N_PE(NPE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_gauss(cmd_gauss), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_dataA(s_dataA), .s_dataB(s_dataB),
    .start_out(start_out), .op_out(op_out),
    .gauss_op_out(gauss_op_out),
    .data_out(data_out), .dataA_out(dataA_out), .dataB_out(dataB_out),
    .res_in(res_in), .m_valid(m_valid), .m_data(m_data),
`ifdef BC_DRV_PERF_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 0;
  bit issued_at [0:MAXC-1];

  logic       exp_cr, exp_sr, exp_start, exp_done;
  logic [3:0] exp_op, exp_d, exp_a, exp_b;
  logic [1:0] exp_g;
  int         exp_stall;
  int         stall_m = 0;
  bit         done_next = 0;
  int         acc_cyc = 0;

  int          st_cyc = 0;
  logic [31:0] mv_mask = 0;
  int          last_done_cyc = -1;
  int          done_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic mv_e;
      mv_e = (cyc >= NPE) && issued_at[cyc-NPE];
      chk("cmd_ready", cmd_ready, exp_cr);
      chk("s_ready", s_ready, exp_sr);
      chk("start_out", start_out, exp_start);
      chk("op_out", op_out, exp_op);
      chk("gauss_op_out", gauss_op_out, exp_g);
      chk("data_out", data_out, exp_d);
      chk("dataA_out", dataA_out, exp_a);
      chk("dataB_out", dataB_out, exp_b);
      chk("m_valid", m_valid, mv_e);
      chk("m_data", m_data, res_in);
      chk("done", done, exp_done);
`ifdef BC_DRV_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, exp_stall);
      if (done) done_stall = stall_cnt;
`endif
      if (start_out) begin
        st_cyc  = cyc;
        mv_mask = 0;
      end
      if (m_valid && cyc >= st_cyc && cyc - st_cyc < 32)
        mv_mask[cyc-st_cyc] = 1'b1;
      if (done) last_done_cyc = cyc;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_data();
    s_data  = 4'($urandom_range(15));
    s_dataA = 4'($urandom_range(15));
    s_dataB = 4'($urandom_range(15));
    res_in  = 4'($urandom_range(15));
  endtask

  task automatic exp_bubble();
    exp_start = 0;
    exp_op    = 0;
    exp_g     = 0;
    exp_d     = 0;
    exp_a     = 0;
    exp_b     = 0;
  endtask

  task automatic idle_cycle();
    cmd_valid = 0;
    s_valid   = 1'($urandom_range(1));
    rand_data();
    exp_cr    = 1;
    exp_sr    = 0;
    exp_bubble();
    exp_done  = done_next;
    done_next = 0;
    exp_stall = stall_m;
    next_cycle();
  endtask

  task automatic do_reset_mid();
    chk_en = 0;
    #2;
    rst_n  = 0;
    res_in = 0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_chain", {start_out, op_out, gauss_op_out,
                      data_out, dataA_out, dataB_out}, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1;
    for (int i = 0; i < MAXC; i++) issued_at[i] = 0;
    stall_m   = 0;
    done_next = 0;
    chk_en    = 1;
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [1:0] g,
                         input logic [7:0] len, input logic [31:0] pat,
                         input bit use_pat, input int pbub,
                         input bit hold, input int abort_at);
    int n;
    int k;
    bit sv;
    cmd_valid = 1;
    cmd_op    = op;
    cmd_gauss = g;
    cmd_len   = len;
    s_valid   = 1'($urandom_range(1));
    rand_data();
    exp_cr    = 1;
    exp_sr    = 0;
    exp_bubble();
    exp_done  = done_next;
    done_next = 0;
    exp_stall = stall_m;
    stall_m   = 0;
    acc_cyc   = cyc;
    next_cycle();
    if (len == 0) begin
      done_next = 1;
      return;
    end
    n = 0;
    k = 0;
    while (n < int'(len)) begin
      cmd_valid = hold;
      cmd_op    = 4'($urandom_range(15));
      cmd_gauss = 2'($urandom_range(3));
      cmd_len   = 8'($urandom_range(255));
      if (use_pat) sv = (k < 32) ? !pat[k] : 1'b1;
      else         sv = ($urandom_range(99) >= pbub);
      k++;
      s_valid = sv;
      rand_data();
      exp_cr    = 0;
      exp_sr    = 1;
      exp_done  = 0;
      exp_stall = stall_m;
      if (sv) begin
        exp_start = (n == 0);
        exp_op    = op;
        exp_g     = g;
        exp_d     = s_data;
        exp_a     = s_dataA;
        exp_b     = s_dataB;
        if (cyc < MAXC) issued_at[cyc] = 1;
        n++;
      end else begin
        exp_bubble();
        stall_m++;
      end
      next_cycle();
    end
    for (int i = 0; i < NPE; i++) begin
      cmd_valid = hold;
      s_valid   = 1'($urandom_range(1));
      rand_data();
      exp_cr    = 0;
      exp_sr    = 0;
      exp_bubble();
      exp_done  = 0;
      exp_stall = stall_m;
      if (i == abort_at) begin
        cmd_valid = 0;
        do_reset_mid();
        return;
      end
      next_cycle();
    end
    done_next = 1;
  endtask

  initial begin
    int saved_done;
    rst_n     = 0;
    cmd_valid = 0;
    cmd_op    = 0;
    cmd_gauss = 0;
    cmd_len   = 0;
    s_valid   = 1;
    s_data    = 4'hF;
    s_dataA   = 4'hF;
    s_dataB   = 4'hF;
    res_in    = 0;
    for (int i = 0; i < MAXC; i++) issued_at[i] = 0;
    #2;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_start", start_out, 0);
    chk("reset_op", op_out, 0);
    chk("reset_data", data_out, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_done", done, 0);
`ifdef BC_DRV_PERF_CNT_EN
    chk("reset_stall", stall_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1;
    chk_en = 1;
    repeat (2) idle_cycle();

    // three back-to-back words, no bubbles
    run_cmd(4'b0100, 2'b11, 8'd3, 32'h0, 1, 0, 0, -1);
    repeat (2) idle_cycle();
    chk("lit_mvalid_nobubble", mv_mask, 32'h70);
    chk("lit_done_nobubble", last_done_cyc - st_cyc, 7);

    // one bubble right after word 0
    run_cmd(4'b0100, 2'b11, 8'd3, 32'h2, 1, 0, 0, -1);
    repeat (2) idle_cycle();
    chk("lit_mvalid_bubble", mv_mask, 32'hD0);
    chk("lit_done_bubble", last_done_cyc - st_cyc, 8);
`ifdef BC_DRV_PERF_CNT_EN
    chk("lit_stall_bubble", done_stall, 1);
`endif

    // zero-length command
    run_cmd(4'h9, 2'b01, 8'd0, 32'h0, 1, 0, 0, -1);
    idle_cycle();
    chk("lit_done_len0", last_done_cyc - acc_cyc, 1);
    idle_cycle();

    // cmd_valid held through a run, next command on the done cycle
    run_cmd(4'h5, 2'b10, 8'd5, 32'h0, 0, 30, 1, -1);
    run_cmd(4'hA, 2'b01, 8'd2, 32'h0, 0, 0, 0, -1);
    repeat (2) idle_cycle();

    // reset during drain aborts the run
    saved_done = last_done_cyc;
    run_cmd(4'h3, 2'b11, 8'd2, 32'h0, 1, 0, 0, 1);
    repeat (NPE + 2) idle_cycle();
    chk("lit_no_done_after_abort", last_done_cyc, saved_done);
    run_cmd(4'h7, 2'b00, 8'd1, 32'h0, 1, 0, 0, -1);
    repeat (2) idle_cycle();

    for (int r = 0; r < 40; r++) begin
      logic [7:0] len;
      len = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(20, 1));
      run_cmd(4'($urandom_range(15)), 2'($urandom_range(3)), len,
              32'h0, 0, int'($urandom_range(50)),
              1'($urandom_range(1)), -1);
      repeat ($urandom_range(2)) idle_cycle();
    end
    repeat (NPE + 2) idle_cycle();
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bc_row_driver.md
BC_ROW_DRIVER -- requirements
Module: bc_row_driver

Interface
REQ-001 SHALL have parameters: GF_BIT, default 4, field element width; OP_CODE_LEN, default 4, op code width; N_PE, default 16, number of processor elements in the driven chain.
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  OP_CODE_LEN  op code for the run
- cmd_gauss  in  2  gauss_op for the run
- cmd_len  in  8  words in the run
- s_valid  in  1  stream word offered
- s_ready  out  1  stream word consumed when high with s_valid
- s_data  in  GF_BIT  stream data word
- s_dataA  in  GF_BIT  stream A word
- s_dataB  in  GF_BIT  stream B word
- start_out  out  1  first-word marker to chain
- op_out  out  OP_CODE_LEN  op to chain
- gauss_op_out  out  2  gauss_op to chain
- data_out  out  GF_BIT  data to chain
- dataA_out  out  GF_BIT  A to chain
- dataB_out  out  GF_BIT  B to chain
- res_in  in  GF_BIT  data_out of last chain element
- m_valid  out  1  result word valid
- m_data  out  GF_BIT  result word
- done  out  1  one-cycle run-complete pulse

Function
REQ-003 SHALL implement FSM states IDLE, STREAM, DRAIN.
REQ-004 cmd_ready SHALL be 1 only in IDLE; on accept, cmd_op/cmd_gauss/cmd_len SHALL be latched.
REQ-005 Accept with cmd_len=0 SHALL stay in IDLE, issue no word, pulse done next cycle.
REQ-006 Accept with cmd_len>0 SHALL enter STREAM next cycle with word counter 0.
REQ-007 In STREAM, s_ready SHALL equal 1; each cycle with s_valid SHALL issue one word: op_out=latched op, gauss_op_out=latched gauss, data/dataA/dataB_out=s_data/s_dataA/s_dataB, counter +1.
REQ-008 start_out SHALL be 1 only on the cycle issuing word 0 of a run.
REQ-009 STREAM cycle with s_valid=0 SHALL issue a bubble: op_out=0, gauss_op_out=2'b00, all data outputs 0, start_out=0, counter unchanged.
REQ-010 Issue of word cmd_len-1 SHALL move to DRAIN next cycle; s_ready SHALL be 0 outside STREAM.
REQ-011 DRAIN SHALL last exactly N_PE cycles issuing bubbles, then return to IDLE with done=1 for one cycle.
REQ-012 Chain outputs SHALL be combinational from state, latched command and stream inputs (zero added latency).
REQ-013 A valid-tag shift register of depth N_PE SHALL shift in 1 per issued word, 0 per bubble; m_valid SHALL be its output, m_data SHALL equal res_in; word k issued at cycle t SHALL appear at cycle t+N_PE.
REQ-014 No result backpressure; m_valid SHALL never be suppressed.
REQ-015 cmd_valid outside IDLE SHALL be ignored without side effects.

Reset
REQ-016 rst_n low SHALL immediately force IDLE, counter 0, tags 0, latched command 0, all outputs 0 except cmd_ready=1.
REQ-017 Reset mid-run SHALL abort: no done, no further m_valid.

Configuration
REQ-018 With BC_DRV_PERF_CNT_EN defined SHALL add output stall_cnt (16 bits) counting STREAM bubble cycles, cleared on command accept and reset, saturating at 16'hFFFF; without it the port and counter SHALL be absent.

Verification
REQ-019 N_PE=4, cmd op=4'b0100 gauss=2'b11 len=3, s_valid constant 1 -> start_out on first word only, three words issued consecutively, m_valid cycles 4..6 after first issue, done after 4 drain cycles.
REQ-020 len=3 with s_valid low one cycle after word 0 -> one bubble (op 0, gauss 00), stall_cnt=1 with macro, m_valid pattern 1,0,1,1.
REQ-021 cmd_len=0 -> no start_out, s_ready stays 0, done one cycle after accept.
REQ-022 rst_n low during DRAIN -> outputs 0 at once, no done, no m_valid after release, cmd_ready=1.
REQ-023 cmd_valid held high during STREAM -> ignored; second command accepted only after done.
